// File: rtl/sysref_pkg.sv
// Shared state encoding and default sizing for the SYSREF alignment block.
package sysref_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } sysref_state_t;

    localparam int PERIOD_W_DEF = 16;
    localparam int LOCK_CNT_DEF = 4;
endpackage

// File: rtl/sysref_sync.sv
// Multi-flop synchroniser for the raw board SYSREF plus rising-edge detect.
module sysref_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic edge_pulse
);
    (* async_reg = "true" *) logic [SYNC_STAGES-1:0] sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/sysref_align.sv
// Period-checked, phase-programmable SYSREF tick generator in the ADC fabric clock domain.
//   state      | meaning
//   ST_IDLE    | disabled, counters cleared
//   ST_SEARCH  | waiting for the first edge (not classified)
//   ST_MEASURE | counting consecutive good periods towards lock
//   ST_LOCKED  | local phase counter free-running, edges only checked
module sysref_align
    import sysref_pkg::*;
#(
    parameter int PERIOD_W    = PERIOD_W_DEF,
    parameter int LOCK_CNT    = LOCK_CNT_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                pl_sysref,
    input  logic                enable,
    input  logic                rearm,
    input  logic [PERIOD_W-1:0] expected_period,
    input  logic [3:0]          tolerance,
    input  logic [PERIOD_W-1:0] phase_offset,
    output logic                sysref_tick,
    output logic                locked,
    output logic                lost,
    output logic                slip,
    output logic [PERIOD_W-1:0] period_meas
);
    localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
    localparam logic [PERIOD_W-1:0] ONE      = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W:0]   ONE_EXT  = {{PERIOD_W{1'b0}}, 1'b1};
    localparam logic [3:0]          LOCK_TGT = 4'(LOCK_CNT);

    sysref_state_t       state;
    logic                sys_edge;
    logic [PERIOD_W-1:0] per_cnt;
    logic [PERIOD_W-1:0] phase;
    logic [PERIOD_W-1:0] phase_inc;
    logic [3:0]          good_cnt;
    logic                to_done;
    logic [PERIOD_W:0]   period_ext;
    logic [PERIOD_W:0]   exp_ext;
    logic [PERIOD_W:0]   tol_ext;
    logic [PERIOD_W:0]   diff;
    logic                per_good;
    logic                per_exact;
    logic                timeout;

    sysref_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rstn       (rstn),
        .din        (pl_sysref),
        .edge_pulse (sys_edge)
    );

    // Extra bit keeps per_cnt+1 and expected+tolerance from wrapping.
    always_comb begin
        period_ext = {1'b0, per_cnt} + ONE_EXT;
        exp_ext    = {1'b0, expected_period};
        tol_ext    = {{(PERIOD_W-3){1'b0}}, tolerance};
        diff       = (period_ext >= exp_ext) ? (period_ext - exp_ext) : (exp_ext - period_ext);
        per_good   = (diff <= tol_ext);
        per_exact  = (period_ext == exp_ext);
        timeout    = !sys_edge && !to_done && (period_ext > (exp_ext + tol_ext));
        phase_inc  = (phase >= (expected_period - ONE)) ? '0 : (phase + ONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            per_cnt     <= '0;
            to_done     <= 1'b0;
            period_meas <= '0;
        end else if (sys_edge) begin
            per_cnt     <= '0;
            to_done     <= 1'b0;
            period_meas <= (per_cnt == CNT_MAX) ? CNT_MAX : (per_cnt + ONE);
        end else begin
            if (per_cnt != CNT_MAX) per_cnt <= per_cnt + ONE;
            if (timeout) to_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            good_cnt    <= '0;
            phase       <= '0;
            locked      <= 1'b0;
            sysref_tick <= 1'b0;
            lost        <= 1'b0;
            slip        <= 1'b0;
        end else begin
            sysref_tick <= 1'b0;
            if (!enable) begin
                state    <= ST_IDLE;
                good_cnt <= '0;
                phase    <= '0;
                locked   <= 1'b0;
                if (rearm) begin
                    lost <= 1'b0;
                    slip <= 1'b0;
                end
            end else if (rearm) begin
                state    <= ST_SEARCH;
                good_cnt <= '0;
                phase    <= '0;
                locked   <= 1'b0;
                lost     <= 1'b0;
                slip     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_SEARCH;
                    ST_SEARCH: begin
                        if (sys_edge) begin
                            state    <= ST_MEASURE;
                            good_cnt <= '0;
                        end
                    end
                    ST_MEASURE: begin
                        if (sys_edge) begin
                            if (!per_good) begin
                                good_cnt <= '0;
                            end else if ((good_cnt + 4'd1) == LOCK_TGT) begin
                                state       <= ST_LOCKED;
                                good_cnt    <= LOCK_TGT;
                                locked      <= 1'b1;
                                phase       <= '0;
                                sysref_tick <= (phase_offset == '0);
                            end else begin
                                good_cnt <= good_cnt + 4'd1;
                            end
                        end else if (timeout) begin
                            good_cnt <= '0;
                            state    <= ST_SEARCH;
                        end
                    end
                    ST_LOCKED: begin
                        if ((sys_edge && !per_good) || timeout) begin
                            lost     <= 1'b1;
                            good_cnt <= '0;
                            locked   <= 1'b0;
                            phase    <= '0;
                            state    <= ST_MEASURE;
                        end else if (sys_edge && !per_exact) begin
                            // Realign on a jittered edge rather than trusting the local count.
                            slip        <= 1'b1;
                            phase       <= '0;
                            sysref_tick <= (phase_offset == '0);
                        end else begin
                            phase       <= phase_inc;
                            sysref_tick <= (phase_inc == phase_offset);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sysref_align.sv
// Self-checking bench: directed lock/slip/loss/control scenarios, then randomized SYSREF trains vs. a reference model.
module tb_sysref_align;
    localparam int PW = 16;
    localparam int SS = 2;
    localparam int LC = 4;
    localparam int M_IDLE = 0, M_SEARCH = 1, M_MEASURE = 2, M_LOCKED = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          pl_sysref = 1'b0;
    logic          enable = 1'b0;
    logic          rearm = 1'b0;
    logic [PW-1:0] expected_period = 16'd8;
    logic [3:0]    tolerance = 4'd0;
    logic [PW-1:0] phase_offset = 16'd3;
    logic          sysref_tick, locked, lost, slip;
    logic [PW-1:0] period_meas;

    sysref_align #(.PERIOD_W(PW), .LOCK_CNT(LC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rstn(rstn), .pl_sysref(pl_sysref), .enable(enable), .rearm(rearm),
        .expected_period(expected_period), .tolerance(tolerance), .phase_offset(phase_offset),
        .sysref_tick(sysref_tick), .locked(locked), .lost(lost), .slip(slip), .period_meas(period_meas)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int m_mode, m_cnt, m_tdone, m_good, m_align, m_lost, m_slip, m_locked, m_tick, m_pmeas;
    int hist [SS+1];
    int tick_q[$];
    int rises[$];
    int first_lock = -1, first_lost = -1;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_tdone = 0; m_good = 0; m_align = 0;
        m_lost = 0; m_slip = 0; m_locked = 0; m_tick = 0; m_pmeas = 0;
        for (int i = 0; i <= SS; i++) hist[i] = 0;
    endtask

    // Predicts the registered outputs after the coming clock edge from the inputs now applied.
    task automatic model_step();
        int e, per, good, tmo, ex, tol, off, nc;
        ex = int'(expected_period); tol = int'(tolerance); off = int'(phase_offset);
        nc = cyc + 1;
        e = (hist[SS-1] != 0 && hist[SS] == 0) ? 1 : 0;
        per = m_cnt + 1;
        good = (((per > ex) ? per - ex : ex - per) <= tol) ? 1 : 0;
        tmo = (e == 0 && m_tdone == 0 && per > ex + tol) ? 1 : 0;
        if (e != 0) m_pmeas = (per > 65535) ? 65535 : per;
        m_cnt = (e != 0) ? 0 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
        m_tdone = (e != 0) ? 0 : ((tmo != 0) ? 1 : m_tdone);
        if (!enable) begin
            m_mode = M_IDLE; m_good = 0;
            if (rearm) begin m_lost = 0; m_slip = 0; end
        end else if (rearm) begin
            m_mode = M_SEARCH; m_good = 0; m_lost = 0; m_slip = 0;
        end else begin
            case (m_mode)
                M_IDLE: m_mode = M_SEARCH;
                M_SEARCH: if (e != 0) begin m_mode = M_MEASURE; m_good = 0; end
                M_MEASURE: begin
                    if (e != 0 && good != 0) begin
                        m_good++;
                        if (m_good == LC) begin m_mode = M_LOCKED; m_align = nc; end
                    end else if (e != 0) m_good = 0;
                    else if (tmo != 0) begin m_good = 0; m_mode = M_SEARCH; end
                end
                default: begin
                    if (e != 0 && per == ex) ;
                    else if (e != 0 && good != 0) begin m_slip = 1; m_align = nc; end
                    else if (e != 0 || tmo != 0) begin m_lost = 1; m_good = 0; m_mode = M_MEASURE; end
                end
            endcase
        end
        m_locked = (m_mode == M_LOCKED) ? 1 : 0;
        m_tick = (m_locked != 0 && ((nc - m_align) % ex) == off) ? 1 : 0;
        for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pl_sysref ? 1 : 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("tick", sysref_tick, m_tick);
        check("locked", locked, m_locked);
        check("lost", lost, m_lost);
        check("slip", slip, m_slip);
        check("period_meas", period_meas, m_pmeas);
        if (sysref_tick) tick_q.push_back(cyc);
        if (locked && first_lock < 0) first_lock = cyc;
        if (lost && first_lost < 0) first_lost = cyc;
    endtask

    task automatic pulse_train(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            pl_sysref = 1'b1;
            rises.push_back(cyc + 1);
            step();
            pl_sysref = 1'b0;
            for (int j = 1; j < per; j++) step();
        end
    endtask

    task automatic idle(input int n);
        pl_sysref = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_rearm();
        rearm = 1'b1;
        step();
        rearm = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tick"}, sysref_tick, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_lost"}, lost, 0);
        check({tag, "_slip"}, slip, 0);
        check({tag, "_pmeas"}, period_meas, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k0, ks, r, gap, ex, jit, tol_i;
        model_reset();
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        enable = 1'b1;
        idle(3);

        // Basic lock: 5th edge locks, tick offset+1 after each edge.
        first_lock = -1; tick_q.delete(); rises.delete();
        pulse_train(6, 8);
        k0 = rises[0];
        check("lock_cycle", first_lock, k0 + 34);
        check("basic_tick_count", tick_q.size(), 2);
        if (tick_q.size() >= 2) begin
            check("first_tick", tick_q[0], k0 + 37);
            check("tick_spacing", tick_q[1] - tick_q[0], 8);
        end
        check("basic_pmeas", period_meas, 8);
        check("basic_slip", slip, 0);

        // Jitter within tolerance: a 9-cycle period realigns the phase.
        tolerance = 4'd1; tick_q.delete(); rises.delete();
        idle(1);
        pulse_train(3, 8);
        ks = rises[0];
        check("jitter_slip", slip, 1);
        check("jitter_locked", locked, 1);
        if (tick_q.size() >= 1) check("jitter_tick", tick_q[0], ks + 5);
        else check("jitter_tick_count", tick_q.size(), 1);

        // Missing edge: timeout at per_cnt+1 = 10, then relock with lost held.
        first_lost = -1; rises.delete();
        pulse_train(1, 8);
        r = rises[0];
        idle(8);
        pulse_train(6, 8);
        check("missing_lost_cycle", first_lost, r + 12);
        check("missing_relock", locked, 1);
        check("missing_lost_sticky", lost, 1);

        // Offset equal to the period: locked but never ticks.
        phase_offset = 16'd8;
        pulse_rearm();
        tick_q.delete();
        pulse_train(8, 8);
        check("oor_locked", locked, 1);
        check("oor_ticks", tick_q.size(), 0);

        // Rearm coinciding with a bad edge wins.
        phase_offset = 16'd3;
        pulse_rearm();
        pulse_train(6, 8);
        pulse_train(1, 4);
        pl_sysref = 1'b1; step();
        pl_sysref = 1'b0; step();
        rearm = 1'b1; step(); rearm = 1'b0;
        check("rearm_lost", lost, 0);
        check("rearm_slip", slip, 0);
        check("rearm_locked", locked, 0);

        // Disable while locked.
        pulse_train(6, 8);
        check("pre_disable_locked", locked, 1);
        enable = 1'b0; step();
        check("disable_locked", locked, 0);
        enable = 1'b1;
        idle(2);

        // Reset mid-lock.
        pulse_train(6, 8);
        check("pre_reset_locked", locked, 1);
        #3;
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        rstn = 1'b1;
        first_lock = -1; rises.delete();
        pulse_train(6, 8);
        check("reset_relock_cycle", first_lock, rises[4] + 2);

        // Randomized trains with jitter, dropouts, enable drops and rearms.
        for (int seg = 0; seg < 25; seg++) begin
            expected_period = PW'($urandom_range(4, 12));
            tolerance = 4'($urandom_range(0, 2));
            phase_offset = PW'($urandom_range(0, int'(expected_period)));
            ex = int'(expected_period);
            tol_i = int'(tolerance);
            pl_sysref = 1'b0;
            enable = 1'b1;
            pulse_rearm();
            gap = ex;
            for (int c = 0; c < 400; c++) begin
                if (gap <= 1) begin
                    pl_sysref = 1'b1;
                    r = $urandom_range(0, 19);
                    if (r == 0) gap = 2 * ex;
                    else if (r <= 2) begin
                        jit = $urandom_range(0, 2 * (tol_i + 1)) - (tol_i + 1);
                        gap = (ex + jit < 2) ? 2 : ex + jit;
                    end else gap = ex;
                end else begin
                    pl_sysref = 1'b0;
                    gap--;
                end
                enable = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
                rearm = ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0;
                step();
            end
            rearm = 1'b0;
            enable = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
